// File: rtl/xm_mem_unit_if.sv
// Memory-port bundle between xm_mem_unit (master) and the external memory (slave).
interface xm_mem_unit_if #(
    parameter int unsigned WORD   = 16,
    parameter int unsigned ADDR_W = 16
);
    localparam int unsigned LANES = WORD / 8;
    localparam int unsigned LSB   = $clog2(LANES);

    logic                    memReq_o;
    logic                    memWe_o;
    logic [LANES-1:0]        memBe_o;
    logic [ADDR_W-LSB-1:0]   memAddr_o;
    logic [WORD-1:0]         memWdata_o;
    logic [WORD-1:0]         memRdata_i;
    logic                    memAck_i;

    modport master (
        output memReq_o, memWe_o, memBe_o, memAddr_o, memWdata_o,
        input  memRdata_i, memAck_i
    );

    modport slave (
        input  memReq_o, memWe_o, memBe_o, memAddr_o, memWdata_o,
        output memRdata_i, memAck_i
    );
endinterface

// File: rtl/xm_mem_unit.sv
// X-Makina memory access unit: one load/store/fetch per request, req/ack bus
// cycle with wait states and timeout, byte-lane steering and fault reporting.
module xm_mem_unit #(
    parameter int unsigned WORD    = 16,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               clk_i,
    input  logic               arst_i,
    input  logic               start_i,
    input  logic               wr_i,
    input  logic               byteOp_i,
    input  logic               ifetch_i,
    input  logic [ADDR_W-1:0]  addr_i,
    input  logic [WORD-1:0]    data_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [1:0]         fault_o,
    output logic [WORD-1:0]    ir_o,
    output logic [WORD-1:0]    mdr_o,
    xm_mem_unit_if.master      mem
);

    localparam int unsigned LANES = WORD / 8;
    localparam int unsigned LSB   = $clog2(LANES);
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] FLT_NONE    = 2'b00;
    localparam logic [1:0] FLT_ALIGN   = 2'b01;
    localparam logic [1:0] FLT_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   mar_q, mar_d;
    logic [WORD-1:0]     omdr_q, omdr_d;
    logic [WORD-1:0]     ir_q, ir_d;
    logic [WORD-1:0]     mdr_q, mdr_d;
    logic                wr_q, wr_d;
    logic                byte_q, byte_d;
    logic                ifetch_q, ifetch_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          fault_q, fault_d;

    logic [LSB-1:0]      lane;
    logic [7:0]          lane_byte;
    logic                in_req;

    assign lane   = mar_q[LSB-1:0];
    assign in_req = (state_q == ST_REQ);

    // Pick the addressed byte lane out of the read word (little-endian lanes).
    always_comb begin
        lane_byte = mem.memRdata_i[{lane, 3'b000} +: 8];
    end

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state_q  <= ST_IDLE;
            mar_q    <= '0;
            omdr_q   <= '0;
            ir_q     <= '0;
            mdr_q    <= '0;
            wr_q     <= 1'b0;
            byte_q   <= 1'b0;
            ifetch_q <= 1'b0;
            cnt_q    <= '0;
            fault_q  <= FLT_NONE;
        end else begin
            state_q  <= state_d;
            mar_q    <= mar_d;
            omdr_q   <= omdr_d;
            ir_q     <= ir_d;
            mdr_q    <= mdr_d;
            wr_q     <= wr_d;
            byte_q   <= byte_d;
            ifetch_q <= ifetch_d;
            cnt_q    <= cnt_d;
            fault_q  <= fault_d;
        end
    end

    // Next-state and register-update logic.
    always_comb begin
        state_d  = state_q;
        mar_d    = mar_q;
        omdr_d   = omdr_q;
        ir_d     = ir_q;
        mdr_d    = mdr_q;
        wr_d     = wr_q;
        byte_d   = byte_q;
        ifetch_d = ifetch_q;
        cnt_d    = cnt_q;
        fault_d  = fault_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    mar_d    = addr_i;
                    omdr_d   = data_i;
                    wr_d     = wr_i;
                    byte_d   = byteOp_i;
                    ifetch_d = ifetch_i;
                    cnt_d    = '0;
                    fault_d  = FLT_NONE;
                    // Misaligned word access never reaches the bus.
                    if (!byteOp_i && (addr_i[LSB-1:0] != '0)) begin
                        state_d = ST_FAULT;
                        fault_d = FLT_ALIGN;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mem.memAck_i) begin
                    // Ack takes priority over a coincident timeout.
                    if (!wr_q) begin
                        if (ifetch_q) begin
                            ir_d = mem.memRdata_i;
                        end else if (byte_q) begin
                            mdr_d = WORD'(lane_byte);
                        end else begin
                            mdr_d = mem.memRdata_i;
                        end
                    end
                    state_d = ST_DONE;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(TIMEOUT)) begin
                        state_d = ST_FAULT;
                        fault_d = FLT_TIMEOUT;
                    end
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_FAULT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Status and bus outputs decode straight from registered state.
    assign busy_o  = (state_q != ST_IDLE);
    assign done_o  = (state_q == ST_DONE) || (state_q == ST_FAULT);
    assign fault_o = fault_q;
    assign ir_o    = ir_q;
    assign mdr_o   = mdr_q;

    assign mem.memReq_o  = in_req;
    assign mem.memWe_o   = in_req && wr_q;
    assign mem.memAddr_o = mar_q[ADDR_W-1:LSB];

    // Byte enables and write-data steering; byte stores replicate on all lanes.
    always_comb begin
        mem.memBe_o    = '0;
        mem.memWdata_o = '0;
        if (in_req) begin
            if (byte_q) begin
                mem.memBe_o    = LANES'(1) << lane;
                mem.memWdata_o = {LANES{omdr_q[7:0]}};
            end else begin
                mem.memBe_o    = '1;
                mem.memWdata_o = omdr_q;
            end
        end
    end

endmodule

// File: tb/tb_xm_mem_unit.sv
// Scoreboard bench for xm_mem_unit: stimulus pushes expected results, a
// negedge monitor pops and compares on every done_o pulse.
module tb_xm_mem_unit;

    logic        clk_i;
    logic        arst_i;
    logic        start_i;
    logic        wr_i;
    logic        byteOp_i;
    logic        ifetch_i;
    logic [15:0] addr_i;
    logic [15:0] data_i;
    logic        busy_o;
    logic        done_o;
    logic [1:0]  fault_o;
    logic [15:0] ir_o;
    logic [15:0] mdr_o;

    xm_mem_unit_if #(.WORD(16), .ADDR_W(16)) mem_bus ();

    xm_mem_unit #(.WORD(16), .ADDR_W(16), .TIMEOUT(15)) dut (
        .clk_i    (clk_i),
        .arst_i   (arst_i),
        .start_i  (start_i),
        .wr_i     (wr_i),
        .byteOp_i (byteOp_i),
        .ifetch_i (ifetch_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .fault_o  (fault_o),
        .ir_o     (ir_o),
        .mdr_o    (mdr_o),
        .mem      (mem_bus)
    );

    typedef struct {
        logic [1:0]  fault;
        logic [15:0] mdr;
        logic [15:0] ir;
        int          lat;
        int          reqc;
        logic [1:0]  be;
        logic        we;
        logic [14:0] addr;
        logic [15:0] wdata;
        int          start_cyc;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_count = 0;
    int req_cnt = 0;
    int req_seen = 0;
    int ack_wait = 0;
    logic [15:0] mem_rdata = 16'h0;

    logic [1:0]  cap_be;
    logic        cap_we;
    logic [14:0] cap_addr;
    logic [15:0] cap_wdata;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory model: ack after ack_wait unacked REQ cycles (negative = never).
    always @(negedge clk_i) begin
        if (mem_bus.memReq_o) begin
            mem_bus.memAck_i   = (ack_wait >= 0) && (req_seen == ack_wait);
            mem_bus.memRdata_i = mem_rdata;
            req_seen = req_seen + 1;
        end else begin
            mem_bus.memAck_i   = 1'b0;
            mem_bus.memRdata_i = 16'h0;
            req_seen = 0;
        end
    end

    // Monitor: capture the bus request, compare on done_o.
    always @(negedge clk_i) begin
        exp_t e;
        if (!arst_i) begin
            req_cnt = 0;
        end else begin
            if (mem_bus.memReq_o) begin
                if (req_cnt == 0) begin
                    cap_be    = mem_bus.memBe_o;
                    cap_we    = mem_bus.memWe_o;
                    cap_addr  = mem_bus.memAddr_o;
                    cap_wdata = mem_bus.memWdata_o;
                end
                req_cnt = req_cnt + 1;
            end
            if (done_o) begin
                done_count = done_count + 1;
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done_o), 32'(0));
                end else begin
                    e = sb.pop_front();
                    check("fault",      32'(fault_o), 32'(e.fault));
                    check("mdr",        32'(mdr_o),   32'(e.mdr));
                    check("ir",         32'(ir_o),    32'(e.ir));
                    check("latency",    32'(cyc - e.start_cyc), 32'(e.lat));
                    check("req_cycles", 32'(req_cnt), 32'(e.reqc));
                    if (e.reqc > 0) begin
                        check("be",   32'(cap_be),   32'(e.be));
                        check("we",   32'(cap_we),   32'(e.we));
                        check("addr", 32'(cap_addr), 32'(e.addr));
                        if (e.we) check("wdata", 32'(cap_wdata), 32'(e.wdata));
                    end
                end
                req_cnt = 0;
            end
        end
    end

    task automatic access(input logic [15:0] a, input logic [15:0] d, input logic w,
                          input logic b, input logic f, input int wt, input logic [15:0] rd,
                          input logic stray, input exp_t e);
        int prev;
        bit seen;
        ack_wait  = wt;
        mem_rdata = rd;
        @(posedge clk_i); #1;
        prev = done_count;
        e.start_cyc = cyc;
        sb.push_back(e);
        addr_i = a; data_i = d; wr_i = w; byteOp_i = b; ifetch_i = f;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        if (stray) begin
            addr_i = 16'h0ABC; data_i = 16'hFFFF; wr_i = 1'b1; byteOp_i = 1'b1;
            @(posedge clk_i); #1;
        end
        start_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (done_count != prev) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk_i); #1;
        end
        if (!seen) check("done_timeout", 32'(done_count), 32'(prev + 1));
        if (seen) begin
            @(posedge clk_i); #1;
        end
    endtask

    function automatic exp_t mk(input logic [1:0] fault, input logic [15:0] mdr,
                                input logic [15:0] ir, input int lat, input int reqc,
                                input logic [1:0] be, input logic we,
                                input logic [14:0] addr, input logic [15:0] wdata);
        exp_t e;
        e.fault = fault; e.mdr = mdr; e.ir = ir; e.lat = lat; e.reqc = reqc;
        e.be = be; e.we = we; e.addr = addr; e.wdata = wdata; e.start_cyc = 0;
        return e;
    endfunction

    initial begin
        int dc;
        arst_i = 1'b0;
        start_i = 1'b0; wr_i = 1'b0; byteOp_i = 1'b0; ifetch_i = 1'b0;
        addr_i = 16'h0; data_i = 16'h0;
        mem_bus.memAck_i = 1'b0;
        mem_bus.memRdata_i = 16'h0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_busy",  32'(busy_o), 32'(0));
        check("rst_done",  32'(done_o), 32'(0));
        check("rst_fault", 32'(fault_o), 32'(0));
        check("rst_req",   32'(mem_bus.memReq_o), 32'(0));
        check("rst_be",    32'(mem_bus.memBe_o), 32'(0));
        check("rst_mdr",   32'(mdr_o), 32'(0));
        check("rst_ir",    32'(ir_o), 32'(0));
        arst_i = 1'b1;

        // word load, zero wait
        access(16'h0102, 16'h0000, 0, 0, 0, 0, 16'hBEEF, 0,
               mk(2'b00, 16'hBEEF, 16'h0000, 2, 1, 2'b11, 0, 15'h0081, 16'h0));
        // byte loads, upper and lower lane
        access(16'h0103, 16'h0000, 0, 1, 0, 0, 16'hA55A, 0,
               mk(2'b00, 16'h00A5, 16'h0000, 2, 1, 2'b10, 0, 15'h0081, 16'h0));
        access(16'h0102, 16'h0000, 0, 1, 0, 0, 16'hA55A, 0,
               mk(2'b00, 16'h005A, 16'h0000, 2, 1, 2'b01, 0, 15'h0081, 16'h0));
        // instruction fetch updates IR only
        access(16'h0200, 16'h0000, 0, 0, 1, 0, 16'h1234, 0,
               mk(2'b00, 16'h005A, 16'h1234, 2, 1, 2'b11, 0, 15'h0100, 16'h0));
        // byte store replicates low byte
        access(16'h0010, 16'h1234, 1, 1, 0, 0, 16'hDEAD, 0,
               mk(2'b00, 16'h005A, 16'h1234, 2, 1, 2'b01, 1, 15'h0008, 16'h3434));
        // word store with two wait states
        access(16'h0020, 16'hCAFE, 1, 0, 0, 2, 16'hDEAD, 0,
               mk(2'b00, 16'h005A, 16'h1234, 4, 3, 2'b11, 1, 15'h0010, 16'hCAFE));
        // unaligned word load faults without a bus cycle
        access(16'h0011, 16'h0000, 0, 0, 0, 0, 16'hFFFF, 0,
               mk(2'b01, 16'h005A, 16'h1234, 1, 0, 2'b11, 0, 15'h0, 16'h0));
        repeat (3) @(posedge clk_i);
        #1;
        check("fault_held_align", 32'(fault_o), 32'(2'b01));
        // no ack: timeout after 15 request cycles
        access(16'h0040, 16'h0000, 0, 0, 0, -1, 16'hFFFF, 0,
               mk(2'b10, 16'h005A, 16'h1234, 16, 15, 2'b11, 0, 15'h0020, 16'h0));
        #1;
        check("fault_held_timeout", 32'(fault_o), 32'(2'b10));
        // ack in the last allowed request cycle succeeds
        access(16'h0040, 16'h0000, 0, 0, 0, 14, 16'h7777, 0,
               mk(2'b00, 16'h7777, 16'h1234, 16, 15, 2'b11, 0, 15'h0020, 16'h0));
        // start while busy is ignored
        dc = done_count;
        access(16'h0030, 16'h0000, 0, 0, 0, 3, 16'h0C0C, 1,
               mk(2'b00, 16'h0C0C, 16'h1234, 5, 4, 2'b11, 0, 15'h0018, 16'h0));
        repeat (4) @(posedge clk_i);
        #1;
        check("stray_start_ignored", 32'(done_count - dc), 32'(1));
        check("stray_busy", 32'(busy_o), 32'(0));

        // reset in the middle of a waited request
        ack_wait = 3;
        mem_rdata = 16'h9999;
        @(posedge clk_i); #1;
        addr_i = 16'h0050; wr_i = 1'b0; byteOp_i = 1'b0; ifetch_i = 1'b0;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        @(posedge clk_i); #1;
        check("mid_req_active", 32'(mem_bus.memReq_o), 32'(1));
        dc = done_count;
        #2 arst_i = 1'b0;
        #1;
        check("arst_req",   32'(mem_bus.memReq_o), 32'(0));
        check("arst_busy",  32'(busy_o), 32'(0));
        check("arst_be",    32'(mem_bus.memBe_o), 32'(0));
        check("arst_mdr",   32'(mdr_o), 32'(0));
        check("arst_ir",    32'(ir_o), 32'(0));
        check("arst_fault", 32'(fault_o), 32'(0));
        repeat (2) @(posedge clk_i);
        #1 arst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        check("arst_no_done", 32'(done_count - dc), 32'(0));
        // first access after reset
        access(16'h0004, 16'h0000, 0, 0, 0, 0, 16'h0042, 0,
               mk(2'b00, 16'h0042, 16'h0000, 2, 1, 2'b11, 0, 15'h0002, 16'h0));

        check("scoreboard_empty", 32'(sb.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
